reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 26 ++
 rtl/reg_dump_ser.sv | 45 ++++
 rtl/reg_dump.sv | 114 +++++++++++
 tb/tb_reg_dump.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_dump_pkg : shared state encodings and constants for the register dumper
// Revision 1.0
// ----------------------------------------------------------------------------
package reg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_SEL   = 3'd2,
    ST_LOAD  = 3'd3,
    ST_SEND  = 3'd4,
    ST_CKSUM = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [7:0] c_sync_byte = 8'hA5;
  localparam logic [4:0] c_last_idx  = 5'd31;

  function automatic logic [7:0] xor_bytes(input logic [31:0] word);
    return word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_ser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_dump_ser : 32-bit word to LSB-first byte serialiser with byte counter
// Revision 1.0
// ----------------------------------------------------------------------------
module reg_dump_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        advance,
  output logic [7:0]  byte_out,
  output logic        last_byte
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_word;
      cnt_d   = 2'd0;
    end else if (advance) begin
      shift_d = {8'h00, shift_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 32'h0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_out  = shift_q[7:0];
  assign last_byte = (cnt_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/reg_dump.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_dump : streams the register file as SYNC, data bytes, XOR checksum
// Revision 1.0
// ----------------------------------------------------------------------------
module reg_dump
  import reg_dump_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = c_sync_byte,
  parameter bit         SKIP_X0   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  dbg_reg_sel,
  input  logic [31:0] dbg_reg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data
);

  localparam logic [4:0] c_first_idx = SKIP_X0 ? 5'd1 : 5'd0;

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  cksum_q, cksum_d;
  logic        ser_load, ser_adv, ser_last;
  logic [7:0]  ser_byte;
  logic        xfer;

  assign out_valid = (state_q == ST_SYNC) || (state_q == ST_SEND) || (state_q == ST_CKSUM);
  assign xfer      = out_valid && out_ready;

  reg_dump_ser u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .load_word (dbg_reg_data),
    .advance   (ser_adv),
    .byte_out  (ser_byte),
    .last_byte (ser_last)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cksum_d  = cksum_q;
    ser_load = 1'b0;
    ser_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SYNC;
          idx_d   = c_first_idx;
          cksum_d = 8'h00;
        end
      end
      ST_SYNC:  if (xfer) state_d = ST_SEL;
      ST_SEL:   state_d = ST_LOAD;
      // Register file is sampled only here, so writes during the dump land
      // in any register not yet loaded.
      ST_LOAD: begin
        ser_load = 1'b1;
        cksum_d  = cksum_q ^ xor_bytes(dbg_reg_data);
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          ser_adv = 1'b1;
          if (ser_last) begin
            if (idx_q == c_last_idx) begin
              state_d = ST_CKSUM;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = ST_SEL;
            end
          end
        end
      end
      ST_CKSUM: if (xfer) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      cksum_q <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cksum_q <= cksum_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_SYNC:  out_data = SYNC_BYTE;
      ST_SEND:  out_data = ser_byte;
      ST_CKSUM: out_data = cksum_q;
      default:  out_data = 8'h00;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign dbg_reg_sel = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_dump : directed self-checking bench for reg_dump (both SKIP_X0 values)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_reg_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy0, busy1, done0, done1, ov0, ov1;
  logic [4:0]  sel0, sel1;
  logic [7:0]  od0, od1;
  logic [31:0] rd0, rd1;
  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rd0 = regs[sel0];
  assign rd1 = regs[sel1];

  reg_dump #(.SYNC_BYTE(8'hA5), .SKIP_X0(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .dbg_reg_sel(sel0), .dbg_reg_data(rd0), .out_valid(ov0),
    .out_ready(out_ready), .out_data(od0)
  );

  reg_dump #(.SYNC_BYTE(8'hA5), .SKIP_X0(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .dbg_reg_sel(sel1), .dbg_reg_data(rd1), .out_valid(ov1),
    .out_ready(out_ready), .out_data(od1)
  );

  bit         mon1 = 1'b0;
  bit         hold_start = 1'b0;
  logic       m_valid, m_done, m_busy;
  logic [7:0] m_data;
  assign m_valid = mon1 ? ov1   : ov0;
  assign m_done  = mon1 ? done1 : done0;
  assign m_busy  = mon1 ? busy1 : busy0;
  assign m_data  = mon1 ? od1   : od0;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  bit         aborted;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input logic v);
    if (mon1) start1 = v;
    else      start0 = v;
  endtask

  task automatic build_exp(input bit skip);
    logic [7:0] ck;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    ck = 8'h00;
    for (int r = (skip ? 1 : 0); r < 32; r++) begin
      for (int k = 0; k < 4; k++) begin
        b = regs[r][8*k +: 8];
        exp_q.push_back(b);
        ck = ck ^ b;
      end
    end
    exp_q.push_back(ck);
  endtask

  task automatic compare_frame(input string tag);
    check({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
  endtask

  task automatic run_frame(input bit do_start, input bit rand_ready, input int write_at,
                           input int start_at, input int rst_at, output bit ab);
    bit         prev_stall;
    logic [7:0] prev_data;
    bit         seen_done;
    bit         clr_start;
    got.delete();
    ab = 1'b0; seen_done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00; clr_start = 1'b0;
    if (do_start) begin
      set_start(1'b1);
      tick();
      if (!hold_start) set_start(1'b0);
    end
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      if (clr_start) begin
        set_start(1'b0);
        clr_start = 1'b0;
      end
      if (m_done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'h0, m_valid}, 32'h1);
          check("stall_data", {24'h0, m_data}, {24'h0, prev_data});
        end
        out_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        prev_stall = m_valid && !out_ready;
        prev_data  = m_data;
        if (m_valid && out_ready) begin
          got.push_back(m_data);
          if (got.size() == write_at) regs[2] = 32'h0000_00FF;
          if (got.size() == start_at) begin
            set_start(1'b1);
            clr_start = 1'b1;
          end
          if (got.size() == rst_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_valid", {31'h0, m_valid}, 32'h0);
            check("rst_busy", {31'h0, m_busy}, 32'h0);
            check("rst_data", {24'h0, m_data}, 32'h0);
            check("rst_done", {31'h0, m_done}, 32'h0);
            repeat (3) tick();
            rst_n = 1'b1;
            out_ready = 1'b1;
            ab = 1'b1;
            return;
          end
        end
        tick();
      end
    end
    out_ready = 1'b1;
    check("done_seen", {31'h0, seen_done}, 32'h1);
    if (!hold_start) begin
      tick();
      check("post_done_low", {31'h0, m_done}, 32'h0);
      check("post_idle", {31'h0, m_busy}, 32'h0);
      tick();
      check("post_stay_idle", {31'h0, m_busy}, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;

    // Reset state
    repeat (2) tick();
    check("rst0_busy", {31'h0, busy0}, 32'h0);
    check("rst0_valid", {31'h0, ov0}, 32'h0);
    check("rst0_done", {31'h0, done0}, 32'h0);
    check("rst0_data", {24'h0, od0}, 32'h0);
    check("rst0_sel", {27'h0, sel0}, 32'h0);
    check("rst1_busy", {31'h0, busy1}, 32'h0);
    check("rst1_valid", {31'h0, ov1}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Full frame, sink always ready
    run_frame(1'b1, 1'b0, -1, -1, -1, aborted);
    build_exp(1'b0);
    compare_frame("basic");
    check("basic_len130", got.size(), 130);
    if (got.size() == 130) begin
      check("basic_x1b0", {24'h0, got[5]}, 32'h01);
      check("basic_x1b3", {24'h0, got[8]}, 32'h10);
      check("basic_x31b0", {24'h0, got[125]}, 32'h1F);
      check("basic_cksum", {24'h0, got[129]}, 32'h10);
    end

    // Random back-pressure
    run_frame(1'b1, 1'b1, -1, -1, -1, aborted);
    compare_frame("stall");

    // start pulsed mid-frame is ignored
    run_frame(1'b1, 1'b0, -1, 10, -1, aborted);
    compare_frame("midstart");

    // x2 rewritten while x1 is on the wire
    run_frame(1'b1, 1'b0, 6, -1, -1, aborted);
    build_exp(1'b0);
    compare_frame("wr_x2");
    if (got.size() >= 13) begin
      check("wr_x2_b0", {24'h0, got[9]}, 32'hFF);
      check("wr_x2_b3", {24'h0, got[12]}, 32'h00);
    end
    regs[2] = 32'h1000_0002;

    // Reset after 40 bytes, then a fresh frame
    run_frame(1'b1, 1'b0, -1, -1, 40, aborted);
    check("rst_aborted", {31'h0, aborted}, 32'h1);
    check("rst_bytes", got.size(), 40);
    tick();
    run_frame(1'b1, 1'b0, -1, -1, -1, aborted);
    build_exp(1'b0);
    compare_frame("after_rst");

    // start held through DONE restarts right after IDLE
    hold_start = 1'b1;
    run_frame(1'b1, 1'b0, -1, -1, -1, aborted);
    compare_frame("hold1");
    tick();
    check("hold_idle", {31'h0, busy0}, 32'h0);
    tick();
    check("hold_resync_busy", {31'h0, busy0}, 32'h1);
    check("hold_resync_data", {24'h0, od0}, 32'hA5);
    hold_start = 1'b0;
    start0 = 1'b0;
    run_frame(1'b0, 1'b0, -1, -1, -1, aborted);
    compare_frame("hold2");

    // SKIP_X0 instance, only x5 nonzero
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[5] = 32'hDEAD_BEEF;
    mon1 = 1'b1;
    run_frame(1'b1, 1'b0, -1, -1, -1, aborted);
    build_exp(1'b1);
    compare_frame("skip");
    check("skip_len126", got.size(), 126);
    if (got.size() == 126) begin
      check("skip_x5b0", {24'h0, got[17]}, 32'hEF);
      check("skip_x5b1", {24'h0, got[18]}, 32'hBE);
      check("skip_x5b2", {24'h0, got[19]}, 32'hAD);
      check("skip_x5b3", {24'h0, got[20]}, 32'hDE);
      check("skip_cksum", {24'h0, got[125]}, 32'h22);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
